// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_pipe
//  Brief    : EX/MEM pipeline register with stall-vector advance/hold/bubble,
//             synchronous flush, multi-cycle EX context return and a
//             saturating consecutive-stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 8,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int SCNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [ADDR_W-1:0]     ex_waddr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_wreg,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [OP_W-1:0]       ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [CNT_W-1:0]      cnt_i,
  input  logic [2*DATA_W-1:0]   hilo_temp_i,
  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wreg,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [OP_W-1:0]       mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [SCNT_W-1:0]     stall_cycles
);

  localparam int              HILO_W   = 2 * DATA_W;
  localparam logic [SCNT_W-1:0] SCNT_MAX = {SCNT_W{1'b1}};
  localparam logic [SCNT_W-1:0] SCNT_ONE = {{(SCNT_W-1){1'b0}}, 1'b1};

  // Everything that travels to MEM as one instruction; cleared as a unit on a bubble.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wreg;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [OP_W-1:0]   aluop;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] reg2;
  } pay_t;

  logic w_stall_ex;
  logic w_stall_mem;
  logic w_unused_stall;
  pay_t w_ex_pay;

  pay_t              pay_q,  pay_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [HILO_W-1:0] hilo_q, hilo_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;

  assign w_stall_ex     = stall[STAGE];
  assign w_stall_mem    = stall[STAGE+1];
  assign w_unused_stall = ^stall;

  assign w_ex_pay = '{
    valid:    ex_valid,
    waddr:    ex_waddr,
    wdata:    ex_wdata,
    wreg:     ex_wreg,
    whilo:    ex_whilo,
    hi:       ex_hi,
    lo:       ex_lo,
    aluop:    ex_aluop,
    mem_addr: ex_mem_addr,
    reg2:     ex_reg2
  };

  // The illegal EX-run/MEM-stalled combination falls into the advance branch.
  always_comb begin
    pay_d  = pay_q;
    cnt_d  = cnt_q;
    hilo_d = hilo_q;
    scnt_d = scnt_q;
    if (flush) begin
      pay_d  = '0;
      cnt_d  = '0;
      hilo_d = '0;
      scnt_d = '0;
    end else if (!w_stall_ex) begin
      pay_d  = w_ex_pay;
      cnt_d  = '0;
      hilo_d = '0;
      scnt_d = '0;
    end else begin
      if (!w_stall_mem) begin
        pay_d = '0;
      end
      cnt_d  = cnt_i;
      hilo_d = hilo_temp_i;
      if (scnt_q != SCNT_MAX) begin
        scnt_d = scnt_q + SCNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_q  <= '0;
      cnt_q  <= '0;
      hilo_q <= '0;
      scnt_q <= '0;
    end else begin
      pay_q  <= pay_d;
      cnt_q  <= cnt_d;
      hilo_q <= hilo_d;
      scnt_q <= scnt_d;
    end
  end

  assign mem_valid    = pay_q.valid;
  assign mem_waddr    = pay_q.waddr;
  assign mem_wdata    = pay_q.wdata;
  assign mem_wreg     = pay_q.wreg;
  assign mem_whilo    = pay_q.whilo;
  assign mem_hi       = pay_q.hi;
  assign mem_lo       = pay_q.lo;
  assign mem_aluop    = pay_q.aluop;
  assign mem_mem_addr = pay_q.mem_addr;
  assign mem_reg2     = pay_q.reg2;
  assign cnt_o        = cnt_q;
  assign hilo_temp_o  = hilo_q;
  assign stall_cycles = scnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_pipe
//  Brief    : Directed self-checking bench for ex_mem_pipe with a per-cycle
//             reference model and hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 8;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int SCNT_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic                ex_valid;
  logic [ADDR_W-1:0]   ex_waddr;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_wreg;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [OP_W-1:0]     ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [CNT_W-1:0]    cnt_i;
  logic [2*DATA_W-1:0] hilo_temp_i;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_wreg;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [OP_W-1:0]     mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [CNT_W-1:0]    cnt_o;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [SCNT_W-1:0]   stall_cycles;

  // Second instance with a 2-bit stall counter to exercise saturation.
  logic                s_valid, s_wreg, s_whilo;
  logic [ADDR_W-1:0]   s_waddr;
  logic [DATA_W-1:0]   s_wdata, s_hi, s_lo, s_mem_addr, s_reg2;
  logic [OP_W-1:0]     s_aluop;
  logic [CNT_W-1:0]    s_cnt_o;
  logic [2*DATA_W-1:0] s_hilo_o;
  logic [1:0]          s_stall_cycles;

  always #5 clk = ~clk;

  ex_mem_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .SCNT_W(SCNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .cnt_i(cnt_i),
    .hilo_temp_i(hilo_temp_i), .mem_valid(mem_valid), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .cnt_o(cnt_o),
    .hilo_temp_o(hilo_temp_o), .stall_cycles(stall_cycles)
  );

  ex_mem_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .SCNT_W(2)
  ) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .cnt_i(cnt_i),
    .hilo_temp_i(hilo_temp_i), .mem_valid(s_valid), .mem_waddr(s_waddr),
    .mem_wdata(s_wdata), .mem_wreg(s_wreg), .mem_whilo(s_whilo),
    .mem_hi(s_hi), .mem_lo(s_lo), .mem_aluop(s_aluop),
    .mem_mem_addr(s_mem_addr), .mem_reg2(s_reg2), .cnt_o(s_cnt_o),
    .hilo_temp_o(s_hilo_o), .stall_cycles(s_stall_cycles)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what MEM must hold after each edge.
  logic                m_valid, m_wreg, m_whilo;
  logic [ADDR_W-1:0]   m_waddr;
  logic [DATA_W-1:0]   m_wdata, m_hi, m_lo, m_addr, m_reg2;
  logic [OP_W-1:0]     m_aluop;
  logic [CNT_W-1:0]    m_cnt;
  logic [2*DATA_W-1:0] m_hilo;
  int                  m_sc, m_sc2;

  task automatic model_nop();
    m_valid = 0; m_wreg = 0; m_whilo = 0; m_waddr = '0; m_wdata = '0;
    m_hi = '0; m_lo = '0; m_addr = '0; m_reg2 = '0; m_aluop = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      model_nop();
      m_cnt = '0; m_hilo = '0; m_sc = 0; m_sc2 = 0;
    end else if (!stall[STAGE]) begin
      m_valid = ex_valid; m_wreg = ex_wreg; m_whilo = ex_whilo;
      m_waddr = ex_waddr; m_wdata = ex_wdata; m_hi = ex_hi; m_lo = ex_lo;
      m_addr = ex_mem_addr; m_reg2 = ex_reg2; m_aluop = ex_aluop;
      m_cnt = '0; m_hilo = '0; m_sc = 0; m_sc2 = 0;
    end else begin
      if (!stall[STAGE+1]) model_nop();
      m_cnt  = cnt_i;
      m_hilo = hilo_temp_i;
      m_sc   = (m_sc + 1 > 255) ? 255 : m_sc + 1;
      m_sc2  = (m_sc2 + 1 > 3) ? 3 : m_sc2 + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(!stall[STAGE] && stall[STAGE+1]))
      else begin
        n_err++;
        $display("FAIL illegal_stall: stall=%b", stall);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_valid",    {63'd0, mem_valid}, {63'd0, m_valid});
      check("mdl_waddr",    64'(mem_waddr),     64'(m_waddr));
      check("mdl_wdata",    64'(mem_wdata),     64'(m_wdata));
      check("mdl_wreg",     {63'd0, mem_wreg},  {63'd0, m_wreg});
      check("mdl_whilo",    {63'd0, mem_whilo}, {63'd0, m_whilo});
      check("mdl_hi",       64'(mem_hi),        64'(m_hi));
      check("mdl_lo",       64'(mem_lo),        64'(m_lo));
      check("mdl_aluop",    64'(mem_aluop),     64'(m_aluop));
      check("mdl_mem_addr", 64'(mem_mem_addr),  64'(m_addr));
      check("mdl_reg2",     64'(mem_reg2),      64'(m_reg2));
      check("mdl_cnt_o",    64'(cnt_o),         64'(m_cnt));
      check("mdl_hilo_o",   hilo_temp_o,        m_hilo);
      check("mdl_scnt",     64'(stall_cycles),  64'(m_sc));
      check("mdl_scnt_sat", 64'(s_stall_cycles), 64'(m_sc2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    stall = '0; flush = 0; ex_valid = 0; ex_waddr = '0; ex_wdata = '0;
    ex_wreg = 0; ex_whilo = 0; ex_hi = '0; ex_lo = '0; ex_aluop = '0;
    ex_mem_addr = '0; ex_reg2 = '0; cnt_i = '0; hilo_temp_i = '0;
  endtask

  task automatic busy_inputs();
    stall = '0; flush = 0; ex_valid = 1; ex_waddr = 5'd31; ex_wdata = 32'hCAFE0001;
    ex_wreg = 1; ex_whilo = 1; ex_hi = 32'h11111111; ex_lo = 32'h22222222;
    ex_aluop = 8'hA5; ex_mem_addr = 32'h80001000; ex_reg2 = 32'h33333333;
    cnt_i = 2'd3; hilo_temp_i = 64'hFEDC_BA98_7654_3210;
  endtask

  initial begin
    int sat_exp [6] = '{1, 2, 3, 3, 3, 3};
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_on = 1;
    tick();
    check("reset_valid", {63'd0, mem_valid}, 64'd0);
    check("reset_scnt",  64'(stall_cycles), 64'd0);

    // Advance
    ex_valid = 1; ex_waddr = 5'd7; ex_wdata = 32'hDEADBEEF; ex_wreg = 1;
    tick();
    check("adv_waddr", 64'(mem_waddr), 64'd7);
    check("adv_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("adv_wreg",  {63'd0, mem_wreg}, 64'd1);
    check("adv_valid", {63'd0, mem_valid}, 64'd1);
    check("adv_cnt",   64'(cnt_o), 64'd0);

    // MADD: bubble carrying context, then completion
    stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'h1_0000_0002;
    tick();
    check("madd_wreg",  {63'd0, mem_wreg}, 64'd0);
    check("madd_valid", {63'd0, mem_valid}, 64'd0);
    check("madd_cnt",   64'(cnt_o), 64'd1);
    check("madd_hilo",  hilo_temp_o, 64'h1_0000_0002);
    stall = '0; ex_whilo = 1; ex_hi = 32'd1; ex_lo = 32'd3; cnt_i = '0; hilo_temp_i = '0;
    tick();
    check("madd_hi",    64'(mem_hi), 64'd1);
    check("madd_lo",    64'(mem_lo), 64'd3);
    check("madd_cnt0",  64'(cnt_o), 64'd0);
    check("madd_hilo0", hilo_temp_o, 64'd0);

    // Hold
    ex_whilo = 0; ex_wdata = 32'h12345678;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h9000_0000 + 32'(i);
      tick();
      check("hold_wdata", 64'(mem_wdata), 64'h12345678);
      check("hold_scnt",  64'(stall_cycles), 64'(i + 1));
    end
    stall = '0; ex_wdata = 32'hAAAA5555;
    tick();
    check("hold_rel_scnt",  64'(stall_cycles), 64'd0);
    check("hold_rel_wdata", 64'(mem_wdata), 64'hAAAA5555);

    // Flush beats hold
    stall = 6'b011111; cnt_i = 2'd2; hilo_temp_i = 64'h55;
    tick();
    check("pre_flush_cnt", 64'(cnt_o), 64'd2);
    flush = 1;
    tick();
    flush = 0;
    check("flush_valid", {63'd0, mem_valid}, 64'd0);
    check("flush_wreg",  {63'd0, mem_wreg}, 64'd0);
    check("flush_whilo", {63'd0, mem_whilo}, 64'd0);
    check("flush_cnt",   64'(cnt_o), 64'd0);
    check("flush_hilo",  hilo_temp_o, 64'd0);
    check("flush_scnt",  64'(stall_cycles), 64'd0);

    // Saturation of the 2-bit counter instance
    stall = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sat_scnt2", 64'(s_stall_cycles), 64'(sat_exp[i]));
      check("sat_scnt8", 64'(stall_cycles), 64'(i + 1));
    end

    // Asynchronous reset pulse mid multi-cycle op
    busy_inputs();
    tick();
    check("busy_aluop", 64'(mem_aluop), 64'hA5);
    stall = 6'b011111;
    tick();
    check("busy_cnt", 64'(cnt_o), 64'd3);
    rst = 1;
    #1;
    check("arst_valid", {63'd0, mem_valid}, 64'd0);
    check("arst_waddr", 64'(mem_waddr), 64'd0);
    check("arst_wdata", 64'(mem_wdata), 64'd0);
    check("arst_aluop", 64'(mem_aluop), 64'd0);
    check("arst_addr",  64'(mem_mem_addr), 64'd0);
    check("arst_cnt",   64'(cnt_o), 64'd0);
    check("arst_hilo",  hilo_temp_o, 64'd0);
    check("arst_scnt",  64'(stall_cycles), 64'd0);
    #1;
    rst = 0;
    stall = '0;
    tick();
    check("post_rst_reg2", 64'(mem_reg2), 64'h33333333);
    check("post_rst_cnt",  64'(cnt_o), 64'd0);

    // A few mixed cycles checked by the model only
    stall = 6'b001111; tick();
    stall = 6'b011111; tick();
    flush = 1; stall = 6'b001111; tick();
    flush = 0; stall = '0; ex_valid = 0; tick();
    tick();

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline register for the five-stage MIPS core, sitting between the execute unit and the memory stage. It latches the register write-back, HI/LO write and memory-access fields, and carries a valid bit. It implements the stall-vector protocol: advance, hold, or bubble insertion. It also carries multi-cycle execute context (step counter, partial HI/LO product) back to EX, adds a synchronous flush path, and counts consecutive stall cycles for performance debug.

## Interface
- DATA_W, 32, datapath width (GPR, HI, LO, memory address, store data)
- ADDR_W, 5, register-file address width
- OP_W, 8, ALU opcode width forwarded for load/store decode
- CNT_W, 2, multi-cycle step counter width
- STALL_W, 6, width of stall vector
- STAGE, 3, stall bit of the producing (EX) stage; STAGE+1 is the consuming (MEM) stage; must satisfy STAGE+1 < STALL_W
- SCNT_W, 8, stall-cycle counter width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  per-stage stall vector, 1 = stop
- flush  in  1  exception/redirect kill, synchronous
- ex_valid  in  1  EX holds a real instruction
- ex_waddr / ex_wdata / ex_wreg  in  ADDR_W / DATA_W / 1  GPR write-back
- ex_whilo / ex_hi / ex_lo  in  1 / DATA_W / DATA_W  HI/LO write-back
- ex_aluop / ex_mem_addr / ex_reg2  in  OP_W / DATA_W / DATA_W  load/store op, address, store data
- cnt_i / hilo_temp_i  in  CNT_W / 2*DATA_W  multi-cycle context from EX
- mem_valid, mem_waddr, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered MEM-side copies
- cnt_o / hilo_temp_o  out  CNT_W / 2*DATA_W  context returned to EX
- stall_cycles  out  SCNT_W  consecutive cycles with stall[STAGE]=1, saturating

## Operation
- Mode per cycle, in priority order:
  - RESET (rst=1, asynchronous)
  - FLUSH (flush=1)
  - BUBBLE (stall[STAGE]=1, stall[STAGE+1]=0)
  - ADVANCE (stall[STAGE]=0)
  - HOLD (stall[STAGE]=1, stall[STAGE+1]=1)
- RESET: all outputs 0. mem_waddr=0 (NOP address), all write enables 0, mem_valid=0, cnt_o=0, hilo_temp_o=0, stall_cycles=0.
- FLUSH: payload outputs and mem_valid cleared as in RESET; cnt_o and hilo_temp_o cleared (aborts any in-flight MADD/MSUB/DIV); stall_cycles cleared. Overrides every stall combination.
- BUBBLE: payload outputs and mem_valid cleared (NOP to MEM); cnt_o<=cnt_i, hilo_temp_o<=hilo_temp_i; stall_cycles increments.
- ADVANCE: every mem_* output loads its ex_* input, mem_valid<=ex_valid; cnt_o and hilo_temp_o cleared (multi-cycle op complete); stall_cycles cleared.
- HOLD: payload outputs and mem_valid unchanged; cnt_o<=cnt_i, hilo_temp_o<=hilo_temp_i; stall_cycles increments.
- stall_cycles saturates at 2^SCNT_W-1 and never wraps.
- A stall with stall[STAGE]=0 and stall[STAGE+1]=1 is illegal under the stall-vector protocol. The block treats it as ADVANCE; the bench flags it as an assertion.
- No combinational path from any input to any output.

## Timing
- Latency: one cycle from ex_* to mem_* in ADVANCE.
- Context round trip: cnt_i captured in BUBBLE/HOLD at edge N appears on cnt_o after edge N and is visible to EX for cycle N+1.
- rst assertion clears outputs immediately, without waiting for clk. Deassertion takes effect at the first rising edge after release.
- flush and stall sampled at the same edge: flush wins.
- Reset mid multi-cycle op: context discarded; EX restarts from cnt=0.

## Test plan
- Reset: drive all inputs nonzero, pulse rst between edges -> all outputs 0 before the next edge; stall_cycles=0.
- Advance: stall=0, ex_valid=1, ex_waddr=5'd7, ex_wdata=32'hDEADBEEF, ex_wreg=1 -> next cycle mem_waddr=7, mem_wdata=DEADBEEF, mem_wreg=1, mem_valid=1, cnt_o=0.
- MADD sequence: stall=6'b001111, cnt_i=1, hilo_temp_i=64'h1_0000_0002 -> mem_wreg=0, mem_valid=0, cnt_o=1, hilo_temp_o echoes input. Then stall=0 with ex_whilo=1, ex_hi=1, ex_lo=3 -> mem_hi=1, mem_lo=3, cnt_o=0, hilo_temp_o=0.
- Hold: load mem_wdata=32'h12345678, then stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata stays 12345678, stall_cycles=1,2,3, then 0 after release.
- Flush priority: stall=6'b011111, cnt_i=2, flush=1 -> next cycle mem_valid=0, all write enables 0, cnt_o=0, hilo_temp_o=0, stall_cycles=0.
- Saturation: SCNT_W=2, hold stall[STAGE]=1 for 6 cycles -> stall_cycles 1,2,3,3,3,3.
